// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loader_pkg
//  Description : Shared constants, FSM state encoding and helpers for the
//                UART command loader (host framing, response codes).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_loader_pkg;

    // Host framing bytes
    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam logic [7:0] CMD_LOAD_PROG = 8'h01;
    localparam logic [7:0] CMD_LOAD_DATA = 8'h02;
    localparam logic [7:0] CMD_EXEC      = 8'h03;

    // Response bytes returned after every frame
    localparam logic [7:0] RSP_ACK       = 8'h5A;
    localparam logic [7:0] RSP_NAK       = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_SIZE  = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DATA  = 3'd4,
        ST_WRITE = 3'd5,
        ST_EXEC  = 3'd6,
        ST_RESP  = 3'd7
    } loader_state_t;

    function automatic logic is_load_cmd(input logic [7:0] cmd);
        return (cmd == CMD_LOAD_PROG) || (cmd == CMD_LOAD_DATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/loader_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : loader_word_packer
//  Description : Little-endian byte-lane accumulator. Byte k of a word lands
//                in lanes [8k+7:8k] and sets strobe bit k. word_ready fires
//                combinationally with the 4th byte or with a byte flagged as
//                the last of the payload; word_data/word_strb then include
//                that byte, and the packer empties itself for the next word.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                clear           - discard any partially packed word
//                byte_valid/data - incoming payload byte
//                last_byte       - current byte is the final payload byte
//                word_ready      - word_data/word_strb valid this cycle
//                word_data       - packed word including the current byte
//                word_strb       - byte enables including the current byte
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        last_byte,
    output logic        word_ready,
    output logic [31:0] word_data,
    output logic [3:0]  word_strb
);

    logic [31:0] r_lanes;
    logic [3:0]  r_strb;
    logic [1:0]  r_idx;

    logic [31:0] w_lanes;
    logic [3:0]  w_strb;

    // Merge the incoming byte so the caller can capture a complete word on
    // the same cycle the triggering byte arrives.
    always_comb begin
        w_lanes = r_lanes;
        w_strb  = r_strb;
        if (byte_valid) begin
            w_lanes[{r_idx, 3'b000} +: 8] = byte_data;
            w_strb[r_idx]                 = 1'b1;
        end
    end

    assign word_ready = byte_valid && ((r_idx == 2'd3) || last_byte);
    assign word_data  = w_lanes;
    assign word_strb  = w_strb;

    always_ff @(posedge clk) begin
        if (rst || clear || word_ready) begin
            r_lanes <= 32'd0;
            r_strb  <= 4'd0;
            r_idx   <= 2'd0;
        end else if (byte_valid) begin
            r_lanes <= w_lanes;
            r_strb  <= w_strb;
            r_idx   <= r_idx + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_loader
//  Description : Parses host frames [A5][CMD][...] from the UART receiver,
//                turns LOAD payloads into little-endian 32-bit word writes,
//                handles EXEC (boot address + timed CPU reset release) and
//                answers every frame with a one-byte ACK/NAK.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                rx_valid, rx_data        - received byte strobe / value
//                mem_req/addr/wdata/wstrb - word write request
//                mem_ready                - write accepted with mem_req
//                cpu_rst, boot_addr       - CPU reset and reset vector
//                tx_valid, tx_data        - response byte to transmitter
//                tx_ready                 - transmitter accepts response
//                busy                     - frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_loader
    import uart_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES   = 65536,
    parameter int RST_PULSE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    output logic        cpu_rst,
    output logic [31:0] boot_addr,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EX_W = $clog2(RST_PULSE_CYCLES + 1);

    loader_state_t r_state;
    loader_state_t w_state_next;

    logic            r_is_load;
    logic            r_err;
    logic [7:0]      r_remaining;
    logic [1:0]      r_byte_cnt;
    logic [31:0]     r_addr;
    logic [TO_W-1:0] r_to_cnt;
    logic [EX_W-1:0] r_ex_cnt;

    logic            w_counting;
    logic            w_timeout;
    logic            w_resp_nak;
    logic            w_pk_valid;
    logic            w_pk_clear;
    logic            w_last;
    logic [31:0]     w_addr_full;
    logic            w_word_ready;
    logic [31:0]     w_word_data;
    logic [3:0]      w_word_strb;

    // Address arrives LSB first; the 4th byte completes it.
    assign w_addr_full = {rx_data, r_addr[31:8]};
    assign w_last      = (r_remaining == 8'd1);

    assign w_counting = (r_state == ST_CMD)  || (r_state == ST_SIZE) ||
                        (r_state == ST_ADDR) || (r_state == ST_DATA);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign w_timeout  = w_counting && !rx_valid &&
                        (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    assign busy = (r_state != ST_IDLE);

    loader_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_pk_clear),
        .byte_valid (w_pk_valid),
        .byte_data  (rx_data),
        .last_byte  (w_last),
        .word_ready (w_word_ready),
        .word_data  (w_word_data),
        .word_strb  (w_word_strb)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state decode and per-cycle control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_resp_nak   = 1'b0;
        w_pk_valid   = 1'b0;
        w_pk_clear   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (rx_valid) begin
                    if (is_load_cmd(rx_data)) begin
                        w_state_next = ST_SIZE;
                    end else if (rx_data == CMD_EXEC) begin
                        w_state_next = ST_ADDR;
                    end else begin
                        w_state_next = ST_RESP;
                        w_resp_nak   = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_next = ST_RESP;
                    w_resp_nak   = 1'b1;
                end
            end
            ST_SIZE: begin
                if (rx_valid) begin
                    w_state_next = ST_ADDR;
                end else if (w_timeout) begin
                    w_state_next = ST_RESP;
                    w_resp_nak   = 1'b1;
                end
            end
            ST_ADDR: begin
                if (rx_valid && (r_byte_cnt == 2'd3)) begin
                    if (w_addr_full[1:0] != 2'b00) begin
                        w_state_next = ST_RESP;
                        w_resp_nak   = 1'b1;
                    end else if (!r_is_load) begin
                        w_state_next = ST_EXEC;
                    end else if (r_remaining == 8'd0) begin
                        w_state_next = ST_RESP;
                        w_resp_nak   = r_err;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end else if (w_timeout) begin
                    w_state_next = ST_RESP;
                    w_resp_nak   = 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    w_pk_valid = 1'b1;
                    if (w_word_ready) begin
                        w_state_next = ST_WRITE;
                    end
                end else if (w_timeout) begin
                    // Partially packed lanes are dropped, never written.
                    w_pk_clear   = 1'b1;
                    w_state_next = ST_RESP;
                    w_resp_nak   = 1'b1;
                end
            end
            ST_WRITE: begin
                if (mem_req && mem_ready) begin
                    if (r_remaining != 8'd0) begin
                        w_state_next = ST_DATA;
                    end else begin
                        w_state_next = ST_RESP;
                        // An overrun on this very cycle still counts.
                        w_resp_nak   = r_err || rx_valid;
                    end
                end
            end
            ST_EXEC: begin
                if (r_ex_cnt == EX_W'(RST_PULSE_CYCLES - 1)) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (tx_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_load   <= 1'b0;
            r_err       <= 1'b0;
            r_remaining <= 8'd0;
            r_byte_cnt  <= 2'd0;
            r_addr      <= 32'd0;
            r_to_cnt    <= '0;
            r_ex_cnt    <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_wstrb   <= 4'd0;
            cpu_rst     <= 1'b1;
            boot_addr   <= 32'd0;
            tx_valid    <= 1'b0;
            tx_data     <= 8'd0;
        end else begin
            // Inter-byte idle timer
            if (rx_valid || (r_state == ST_IDLE)) begin
                r_to_cnt <= '0;
            end else if (w_counting) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            if (r_state == ST_IDLE) begin
                r_byte_cnt <= 2'd0;
            end

            if ((r_state == ST_CMD) && rx_valid) begin
                r_is_load <= is_load_cmd(rx_data);
                // Halt the CPU for the duration of any load.
                if (is_load_cmd(rx_data)) begin
                    cpu_rst <= 1'b1;
                end
            end

            if ((r_state == ST_SIZE) && rx_valid) begin
                r_remaining <= rx_data;
            end

            if ((r_state == ST_ADDR) && rx_valid) begin
                r_addr     <= w_addr_full;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end

            if ((r_state == ST_DATA) && rx_valid) begin
                r_remaining <= r_remaining - 8'd1;
                if (w_word_ready) begin
                    mem_req   <= 1'b1;
                    mem_addr  <= r_addr;
                    mem_wdata <= w_word_data;
                    mem_wstrb <= w_word_strb;
                end
            end

            if (r_state == ST_WRITE) begin
                if (rx_valid) begin
                    r_err <= 1'b1;
                end
                if (mem_req && mem_ready) begin
                    mem_req <= 1'b0;
                    r_addr  <= r_addr + 32'd4;
                end
            end

            if ((r_state == ST_ADDR) && (w_state_next == ST_EXEC)) begin
                boot_addr <= w_addr_full;
                cpu_rst   <= 1'b1;
                r_ex_cnt  <= '0;
            end

            if (r_state == ST_EXEC) begin
                r_ex_cnt <= r_ex_cnt + EX_W'(1);
                if (w_state_next == ST_RESP) begin
                    cpu_rst <= 1'b0;
                end
            end

            if ((r_state != ST_RESP) && (w_state_next == ST_RESP)) begin
                tx_valid <= 1'b1;
                tx_data  <= w_resp_nak ? RSP_NAK : RSP_ACK;
            end

            if (r_state == ST_RESP) begin
                if (rx_valid) begin
                    r_err <= 1'b1;
                end
                if (tx_ready) begin
                    tx_valid <= 1'b0;
                    r_err    <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
